// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Seven-segment pattern constants (active-low {g,f,e,d,c,b,a})
//               and digit-count shared by the BCD scan display.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int unsigned c_NUM_DIGITS = 4;

    localparam logic [6:0] c_SEG_BLANK = 7'h7F;
    localparam logic [6:0] c_SEG_DASH  = 7'h3F;

    localparam logic [6:0] c_SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [3:0] c_AN_OFF = 4'hF;

    // One-hot active-low anode for a digit index.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg
// Description : Combinational BCD nibble to active-low seven-segment decode;
//               non-decimal nibbles render as a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = c_SEG_DASH;
        if (nibble < 4'd10) begin
            seg = c_SEG_DIGIT[nibble];
        end
    end

endmodule : bcd_to_seg
`default_nettype wire

// File: rtl/bcd_sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_sevenseg_scan
// Description : Four-digit multiplexed seven-segment driver for packed BCD.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_sevenseg_scan
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        rdy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        disp_valid
);

    localparam int unsigned      c_CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);

    logic [c_CNT_W-1:0] r_refresh_cnt;
    logic [1:0]         r_digit_idx;
    logic [15:0]        r_disp;
    logic               r_valid;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    logic               w_wrap;
    logic [3:0]         w_nibble;
    logic [6:0]         w_dec_seg;
    logic               w_blank;

    assign w_wrap   = (r_refresh_cnt == c_CNT_LAST);
    assign w_nibble = r_disp[{r_digit_idx, 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= 2'd0;
        end else if (w_wrap) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= r_digit_idx + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp  <= 16'h0000;
            r_valid <= 1'b0;
        end else if (rdy) begin
            r_disp  <= bcd_in;
            r_valid <= 1'b1;
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble (w_nibble),
        .seg    (w_dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // w_upper_zero[i] is set when digit i and all higher digits are zero.
    logic [c_NUM_DIGITS-1:0] w_upper_zero;

    for (genvar gi = 0; gi < c_NUM_DIGITS; gi++) begin : g_upper_zero
        assign w_upper_zero[gi] = ~|r_disp[4*c_NUM_DIGITS-1 : 4*gi];
    end

    assign w_blank = (r_digit_idx != 2'd0) && w_upper_zero[r_digit_idx];
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= c_AN_OFF;
            r_seg <= c_SEG_BLANK;
        end else if (!r_valid || w_blank) begin
            r_an  <= c_AN_OFF;
            r_seg <= c_SEG_BLANK;
        end else begin
            r_an  <= anode_for(r_digit_idx);
            r_seg <= w_dec_seg;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = 1'b1;
    assign disp_valid = r_valid;

endmodule : bcd_sevenseg_scan
`default_nettype wire

// File: tb/tb_bcd_sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_sevenseg_scan
// Description : Self-checking bench for bcd_sevenseg_scan with REFRESH_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_sevenseg_scan;

    localparam int c_RD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [15:0] bcd_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        disp_valid;

    int errors = 0;
    int checks = 0;

    bcd_sevenseg_scan #(.REFRESH_DIV(c_RD)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .rdy        (rdy),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .disp_valid (disp_valid)
    );

    always #5 clk = ~clk;

    // Reference: digit slot depends only on edges counted since reset.
    function automatic logic [6:0] ref_digit_seg(input logic [3:0] v);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (v > 4'd9) return 7'h3F;
        return tbl[v];
    endfunction

    function automatic bit ref_blank(input logic [15:0] d, input int slot);
        bit en;
`ifdef LEADING_ZERO_BLANK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && (slot > 0) && ((d >> (4 * slot)) == 16'h0000);
    endfunction

    function automatic logic [3:0] ref_an(input logic [15:0] d, input int slot, input bit valid);
        if (!valid || ref_blank(d, slot)) return 4'hF;
        return ~(4'b0001 << slot);
    endfunction

    function automatic logic [6:0] ref_seg(input logic [15:0] d, input int slot, input bit valid);
        if (!valid || ref_blank(d, slot)) return 7'h7F;
        return ref_digit_seg(d[4*slot +: 4]);
    endfunction

    int          m_edges;
    logic [15:0] m_disp;
    bit          m_valid;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edges <= 0;
            m_disp  <= 16'h0000;
            m_valid <= 1'b0;
            exp_an  <= 4'hF;
            exp_seg <= 7'h7F;
        end else begin
            exp_an  <= ref_an(m_disp, (m_edges / c_RD) % 4, m_valid);
            exp_seg <= ref_seg(m_disp, (m_edges / c_RD) % 4, m_valid);
            m_edges <= m_edges + 1;
            if (rdy) begin
                m_disp  <= bcd_in;
                m_valid <= 1'b1;
            end
        end
    end

    // Slot currently shown on the outputs (state before the latest edge).
    function automatic int shown_slot();
        return ((m_edges - 1) / c_RD) % 4;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic capture(input logic [15:0] v);
        bcd_in = v;
        rdy    = 1'b1;
        tick();
        rdy    = 1'b0;
    endtask

    task automatic test_reset();
        capture(16'h1234);
        repeat (6) tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an actual=%h expected=f", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg actual=%h expected=7f", seg); end
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b expected=0", disp_valid); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp actual=%b expected=1", dp); end
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            checks++; if (an !== 4'hF || seg !== 7'h7F) begin errors++; $display("FAIL post_reset_idle actual=%h/%h expected=f/7f", an, seg); end
        end
    endtask

    task automatic test_capture_decode();
        bit saw0 = 0, saw1 = 0;
        capture(16'h0029);
        bcd_in = 16'h5555;
        checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL capture_valid actual=%b expected=1", disp_valid); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (an !== exp_an || seg !== exp_seg) begin errors++; $display("FAIL capture_model actual=%h/%h expected=%h/%h", an, seg, exp_an, exp_seg); end
            if (an === 4'b1110) begin saw0 = 1; checks++; if (seg !== 7'h10) begin errors++; $display("FAIL digit0_nine actual=%h expected=10", seg); end end
            if (an === 4'b1101) begin saw1 = 1; checks++; if (seg !== 7'h24) begin errors++; $display("FAIL digit1_two actual=%h expected=24", seg); end end
        end
        checks++; if (!(saw0 && saw1)) begin errors++; $display("FAIL capture_slots_seen actual=%0d%0d expected=11", saw0, saw1); end
    endtask

    task automatic test_rotation();
        rst = 1'b1;
        tick();
        bcd_in = 16'h1234;
        rdy    = 1'b1;
        rst    = 1'b0;
        for (int n = 1; n <= 36; n++) begin
            tick();
            rdy = 1'b0;
            if (n == 1) begin
                checks++; if (an !== 4'hF) begin errors++; $display("FAIL rotation_first actual=%h expected=f", an); end
            end else begin
                checks++; if (an !== ~(4'b0001 << (((n - 1) / 4) % 4))) begin errors++; $display("FAIL rotation_an edge=%0d actual=%h expected=%h", n, an, ~(4'b0001 << (((n - 1) / 4) % 4))); end
                checks++; if (seg !== exp_seg) begin errors++; $display("FAIL rotation_seg actual=%h expected=%h", seg, exp_seg); end
            end
        end
    endtask

    task automatic test_leading_zero();
        int seen = 0;
        capture(16'h0029);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (shown_slot() >= 2 && m_edges > 1) begin
                seen++;
`ifdef LEADING_ZERO_BLANK_EN
                checks++; if (an !== 4'hF || seg !== 7'h7F) begin errors++; $display("FAIL lz_blank slot=%0d actual=%h/%h expected=f/7f", shown_slot(), an, seg); end
`else
                checks++; if (an !== ~(4'b0001 << shown_slot()) || seg !== 7'h40) begin errors++; $display("FAIL lz_shown slot=%0d actual=%h/%h expected=%h/40", shown_slot(), an, seg, ~(4'b0001 << shown_slot())); end
`endif
            end
        end
        checks++; if (seen < 8) begin errors++; $display("FAIL lz_slots_seen actual=%0d expected>=8", seen); end
    endtask

    task automatic test_non_bcd();
        capture(16'h00A0);
        tick();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) bcd_in = 16'h0031;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (shown_slot() == 1) begin
                    checks++; if (an !== 4'b1101 || seg !== 7'h3F) begin errors++; $display("FAIL non_bcd_dash phase=%0d actual=%h/%h expected=d/3f", phase, an, seg); end
                end else if (shown_slot() == 0) begin
                    checks++; if (an !== 4'b1110 || seg !== 7'h40) begin errors++; $display("FAIL non_bcd_zero phase=%0d actual=%h/%h expected=e/40", phase, an, seg); end
                end
            end
        end
    endtask

    task automatic test_coincident();
        int budget = 0;
        while ((m_edges % 16) != 3 && budget < 20) begin
            tick();
            budget++;
        end
        checks++; if ((m_edges % 16) != 3) begin errors++; $display("FAIL coincident_align actual=%0d expected=3", m_edges % 16); end
        capture(16'h0030);
        checks++; if (an !== exp_an || seg !== exp_seg) begin errors++; $display("FAIL coincident_old actual=%h/%h expected=%h/%h", an, seg, exp_an, exp_seg); end
        tick();
        checks++; if (an !== 4'b1101 || seg !== 7'h30) begin errors++; $display("FAIL coincident_new actual=%h/%h expected=d/30", an, seg); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rdy    = (($urandom % 4) == 0);
            bcd_in = ($urandom % 2) ? 16'($urandom) : 16'($urandom % 256);
            if (i == 150) begin
                #2 rst = 1'b1;
                #1;
                checks++; if (an !== 4'hF || seg !== 7'h7F || disp_valid !== 1'b0) begin errors++; $display("FAIL random_reset actual=%h/%h/%b expected=f/7f/0", an, seg, disp_valid); end
                tick();
                rst = 1'b0;
            end
            tick();
            checks++; if (an !== exp_an || seg !== exp_seg || dp !== 1'b1 || disp_valid !== m_valid) begin
                errors++;
                $display("FAIL random_model cyc=%0d actual=%h/%h/%b/%b expected=%h/%h/1/%b", i, an, seg, dp, disp_valid, exp_an, exp_seg, m_valid);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        rdy    = 1'b0;
        bcd_in = 16'h0000;
        repeat (2) tick();
        rst = 1'b0;
        test_reset();
        test_capture_decode();
        test_rotation();
        test_leading_zero();
        test_non_bcd();
        test_coincident();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_bcd_sevenseg_scan
`default_nettype wire

// File: doc/bcd_sevenseg_scan.md
BCD_SEVENSEG_SCAN -- requirements
Module: bcd_sevenseg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clk cycles each digit is held (1 kHz per digit at 100 MHz); minimum 2.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port bcd_in  input  16  four packed BCD digits from the binary-to-BCD stage; [3:0] is the ones digit (digit 0).
REQ-005 SHALL have port rdy  input  1  conversion-complete strobe from the binary-to-BCD stage; bcd_in is valid while rdy=1.
REQ-006 SHALL have port an  output  4  active-low digit anodes; an[i] drives digit i.
REQ-007 SHALL have port seg  output  7  active-low cathodes {g,f,e,d,c,b,a}.
REQ-008 SHALL have port dp  output  1  decimal point, active-low; constant 1 (off).
REQ-009 SHALL have port disp_valid  output  1  high once a value has been captured since reset.

Function
REQ-010 SHALL capture bcd_in into an internal display register on every rising edge where rdy=1; rdy held high recaptures every cycle.
REQ-011 SHALL set disp_valid on the edge where the first capture occurs; it stays set until reset.
REQ-012 SHALL run a refresh counter 0..REFRESH_DIV-1 that wraps to 0; on wrap, the digit index advances 0->1->2->3->0.
REQ-013 SHALL register an and seg, so outputs reflect the digit index and display register from the previous cycle (1-cycle latency).
REQ-014 SHALL drive an one-hot low for the current digit: index 0->1110, 1->1101, 2->1011, 3->0111.
REQ-015 SHALL decode nibbles 0-9 with these seg values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-016 SHALL display a dash (seg=3F) for nibble values A-F.
REQ-017 SHALL drive an=1111 and seg=7F while disp_valid=0.
REQ-018 SHALL apply a capture and a refresh wrap occurring in the same cycle together; the new digit index shows the new data one cycle later.
REQ-019 SHALL use each captured value unchanged until the next rdy; bcd_in changes without rdy are ignored.

Reset
REQ-020 SHALL on rst=1, immediately and asynchronously, force an=1111, seg=7F, dp=1, disp_valid=0, refresh counter 0, digit index 0, display register 0000.
REQ-021 SHALL apply REQ-020 even when rst asserts mid-scan or coincides with rdy (reset wins).
REQ-022 SHALL start the scan at digit 0 on the first rising edge after rst deasserts.

Configuration
REQ-023 SHALL, when LEADING_ZERO_BLANK_EN is defined, hold an[i]=1 and seg=7F during the slot of digit i (i=3..1) when digit i and every higher digit are 0; digit 0 is never blanked.
REQ-024 SHALL, when LEADING_ZERO_BLANK_EN is undefined, display all four digits, including leading zeros.

Structure
REQ-025 SHALL place the segment pattern constants (0-9, dash, blank) and the digit-count constant in shared package seg_pkg.
REQ-026 SHALL implement the nibble-to-segment decode as combinational sub-module bcd_to_seg (4-bit in, 7-bit active-low out), instantiated once.

Verification (bench uses REFRESH_DIV=4)
REQ-027 SHALL cover reset: assert rst mid-scan -> an=1111, seg=7F, disp_valid=0 within the same timestep.
REQ-028 SHALL cover capture and decode: bcd_in=0029 with a one-cycle rdy pulse -> disp_valid=1; digit 0 slot shows seg=10, digit 1 slot shows seg=24.
REQ-029 SHALL cover rotation: an cycles 1110,1101,1011,0111, each held exactly 4 cycles, then repeats.
REQ-030 SHALL cover leading zeros with bcd_in=0029:
  - LEADING_ZERO_BLANK_EN defined -> digit 3 and 2 slots have an=1111, seg=7F.
  - LEADING_ZERO_BLANK_EN undefined -> digit 3 and 2 slots show seg=40.
REQ-031 SHALL cover non-BCD input and ignored changes: capture bcd_in=00A0 -> digit 1 slot shows seg=3F; then change bcd_in to 0031 with rdy=0 -> display unchanged.
REQ-032 SHALL cover coincident events: rdy pulse on a refresh-wrap cycle with bcd_in=0030 -> next slot (digit 1) shows seg=30.
